// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: binary count, bouncing scanner, rotating one-hot, PWM breathing.
// Optional build macro LED_ACTIVE_LOW_EN inverts LED_o for boards with active-low LEDs.
//
// state  | meaning
// -------+-------------------------------------------------
// BIN    | LED_o shows a free-stepping binary counter
// SCAN   | single lit LED bouncing end to end
// ROT    | single lit LED rotating left, MSB wraps to LSB
// BREATH | all LEDs PWM-driven with a bouncing duty cycle
module led_pattern_gen #(
  parameter int N_LEDS   = 8,
  parameter int CLK_HZ   = 12000000,
  parameter int STEP_HZ  = 8,
  parameter int PWM_BITS = 4
) (
  input  logic              CLK_i,
  input  logic              RST_N_i,
  input  logic [1:0]        MODE_i,
  input  logic              PAUSE_i,
  output logic [N_LEDS-1:0] LED_o,
  output logic              STEP_o
);

  localparam logic [1:0] ST_BIN    = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_ROT    = 2'd2;
  localparam logic [1:0] ST_BREATH = 2'd3;

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [CNT_W-1:0]    PRESC_TOP = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0]    POS_MAX   = POS_W'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [N_LEDS-1:0]   ROT_INIT  = N_LEDS'(1);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [N_LEDS-1:0]   LED_OFF   = '1;
`else
  localparam logic [N_LEDS-1:0]   LED_OFF   = '0;
`endif

  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [N_LEDS-1:0]   bin_q, bin_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                scan_dn_q, scan_dn_d;
  logic [N_LEDS-1:0]   rot_q, rot_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_dn_q, duty_dn_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_LEDS-1:0]   led_pat, led_d;
  logic                step_d;
  logic                mode_chg, tick;

  // Prescaler runs as a down-counter from DIV-1; reaching zero is the tick point.
  assign mode_chg = (MODE_i != mode_q);
  assign tick     = (presc_q == '0) && !PAUSE_i;

  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    bin_d     = bin_q;
    pos_d     = pos_q;
    scan_dn_d = scan_dn_q;
    rot_d     = rot_q;
    duty_d    = duty_q;
    duty_dn_d = duty_dn_q;
    pwm_d     = pwm_q + 1'b1;
    step_d    = 1'b0;
    led_pat   = '0;

    if (mode_chg) begin
      mode_d    = MODE_i;
      presc_d   = PRESC_TOP;
      bin_d     = '0;
      pos_d     = '0;
      scan_dn_d = 1'b0;
      rot_d     = ROT_INIT;
      duty_d    = '0;
      duty_dn_d = 1'b0;
      pwm_d     = '0;
    end else begin
      if (!PAUSE_i)
        presc_d = (presc_q == '0) ? PRESC_TOP : presc_q - 1'b1;
      if (tick) begin
        step_d = 1'b1;
        case (mode_q)
          ST_BIN:  bin_d = bin_q + 1'b1;
          ST_SCAN: begin
            if (N_LEDS > 1) begin
              if (!scan_dn_q) begin
                if (pos_q == POS_MAX) begin
                  scan_dn_d = 1'b1;
                  pos_d     = pos_q - 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end else begin
                if (pos_q == '0) begin
                  scan_dn_d = 1'b0;
                  pos_d     = pos_q + 1'b1;
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
            end
          end
          ST_ROT:  rot_d = (rot_q << 1) | (rot_q >> (N_LEDS - 1));
          default: begin
            if (!duty_dn_q) begin
              if (duty_q == DUTY_MAX) begin
                duty_dn_d = 1'b1;
                duty_d    = duty_q - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                duty_dn_d = 1'b0;
                duty_d    = duty_q + 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
        endcase
      end
    end

    // LED register is loaded from the next state so it always matches the held pattern state.
    case (mode_d)
      ST_BIN:  led_pat = bin_d;
      ST_SCAN: led_pat = ROT_INIT << pos_d;
      ST_ROT:  led_pat = rot_d;
      default: led_pat = {N_LEDS{pwm_d < duty_d}};
    endcase
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led_d = ~led_pat;
`else
  assign led_d = led_pat;
`endif

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      mode_q    <= ST_BIN;
      presc_q   <= PRESC_TOP;
      bin_q     <= '0;
      pos_q     <= '0;
      scan_dn_q <= 1'b0;
      rot_q     <= ROT_INIT;
      duty_q    <= '0;
      duty_dn_q <= 1'b0;
      pwm_q     <= '0;
      LED_o     <= LED_OFF;
      STEP_o    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      bin_q     <= bin_d;
      pos_q     <= pos_d;
      scan_dn_q <= scan_dn_d;
      rot_q     <= rot_d;
      duty_q    <= duty_d;
      duty_dn_q <= duty_dn_d;
      pwm_q     <= pwm_d;
      LED_o     <= led_d;
      STEP_o    <= step_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=4, DIV=16, PWM_BITS=2.
// Honours LED_ACTIVE_LOW_EN when the same macro is defined for the bench.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       pause;
  logic [3:0] led;
  logic       step;

  int checks = 0;
  int passed = 0;

  led_pattern_gen #(.N_LEDS(4), .CLK_HZ(16), .STEP_HZ(1), .PWM_BITS(2)) dut (
    .CLK_i(clk), .RST_N_i(rst_n), .MODE_i(mode), .PAUSE_i(pause),
    .LED_o(led), .STEP_o(step)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] el(input logic [3:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Counts falling edges until STEP_o is seen, bounded.
  task automatic wait_step(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (step === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n; bit ok;
    logic [3:0] want;
    rst_n = 1'b0; mode = 2'd0; pause = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== el(4'h0)) $display("FAIL reset_led got %h want %h", led, el(4'h0)); else passed++;
    checks++; if (step !== 1'b0) $display("FAIL reset_step got %b want 0", step); else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_step(n, ok);
      want = 4'((i + 1) % 16);
      checks++; if (!ok || n != 16) $display("FAIL bin_period%0d got %0d want 16", i, n); else passed++;
      checks++; if (led !== el(want)) $display("FAIL bin_led%0d got %h want %h", i, led, el(want)); else passed++;
    end
  endtask

  task automatic test_scan();
    int n; bit ok;
    logic [3:0] exp_seq [8] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
    mode = 2'd1;
    @(negedge clk);
    checks++; if (led !== el(4'h1)) $display("FAIL scan_start got %h want %h", led, el(4'h1)); else passed++;
    checks++; if (step !== 1'b0) $display("FAIL scan_switch_step got %b want 0", step); else passed++;
    for (int i = 0; i < 8; i++) begin
      wait_step(n, ok);
      checks++; if (!ok || n != 16) $display("FAIL scan_period%0d got %0d want 16", i, n); else passed++;
      checks++; if (led !== el(exp_seq[i])) $display("FAIL scan_led%0d got %h want %h", i, led, el(exp_seq[i])); else passed++;
    end
  endtask

  task automatic test_rot();
    int n; bit ok;
    logic [3:0] exp_seq [5] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    mode = 2'd2;
    @(negedge clk);
    checks++; if (led !== el(4'h1)) $display("FAIL rot_start got %h want %h", led, el(4'h1)); else passed++;
    for (int i = 0; i < 5; i++) begin
      wait_step(n, ok);
      checks++; if (!ok || n != 16) $display("FAIL rot_period%0d got %0d want 16", i, n); else passed++;
      checks++; if (led !== el(exp_seq[i])) $display("FAIL rot_led%0d got %h want %h", i, led, el(exp_seq[i])); else passed++;
    end
  endtask

  task automatic test_breath();
    int n, lit, bad; bit ok;
    int exp_duty [7] = '{0, 1, 2, 3, 2, 1, 0};
    mode = 2'd3;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        @(negedge clk);
      end else begin
        wait_step(n, ok);
        checks++; if (!ok) $display("FAIL breath_step%0d got timeout want pulse", i); else passed++;
      end
      lit = 0; bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (c != 0) @(negedge clk);
        if (led === el(4'hF)) lit++;
        else if (led !== el(4'h0)) bad++;
      end
      checks++; if (lit != exp_duty[i] || bad != 0) $display("FAIL breath_duty%0d got lit %0d mixed %0d want lit %0d mixed 0", i, lit, bad, exp_duty[i]); else passed++;
    end
  endtask

  task automatic test_pause();
    int n, moved, pulses; bit ok;
    mode = 2'd0;
    @(negedge clk);
    checks++; if (led !== el(4'h0)) $display("FAIL pause_switch_led got %h want %h", led, el(4'h0)); else passed++;
    wait_step(n, ok);
    wait_step(n, ok);
    checks++; if (!ok || led !== el(4'h2)) $display("FAIL pause_pre_led got %h want %h", led, el(4'h2)); else passed++;
    repeat (5) @(negedge clk);
    pause = 1'b1;
    moved = 0; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led !== el(4'h2)) moved++;
      if (step !== 1'b0) pulses++;
    end
    pause = 1'b0;
    checks++; if (moved != 0) $display("FAIL pause_led_frozen got %0d changes want 0", moved); else passed++;
    checks++; if (pulses != 0) $display("FAIL pause_no_step got %0d pulses want 0", pulses); else passed++;
    wait_step(n, ok);
    checks++; if (!ok || n != 11) $display("FAIL pause_resume_delay got %0d want 11", n); else passed++;
    checks++; if (led !== el(4'h3)) $display("FAIL pause_resume_led got %h want %h", led, el(4'h3)); else passed++;
  endtask

  task automatic test_switch_on_tick();
    int n; bit ok;
    mode = 2'd1;
    @(negedge clk);
    wait_step(n, ok);
    wait_step(n, ok);
    checks++; if (!ok || led !== el(4'h4)) $display("FAIL swt_pre_led got %h want %h", led, el(4'h4)); else passed++;
    repeat (15) @(negedge clk);
    mode = 2'd0;
    @(negedge clk);
    checks++; if (led !== el(4'h0)) $display("FAIL swt_led got %h want %h", led, el(4'h0)); else passed++;
    checks++; if (step !== 1'b0) $display("FAIL swt_step got %b want 0", step); else passed++;
    wait_step(n, ok);
    checks++; if (!ok || n != 16) $display("FAIL swt_next_tick got %0d want 16", n); else passed++;
    checks++; if (led !== el(4'h1)) $display("FAIL swt_next_led got %h want %h", led, el(4'h1)); else passed++;
  endtask

  task automatic test_mid_reset();
    int n; bit ok;
    mode = 2'd2;
    @(negedge clk);
    wait_step(n, ok);
    wait_step(n, ok);
    checks++; if (!ok || led !== el(4'h4)) $display("FAIL mrst_pre_led got %h want %h", led, el(4'h4)); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (led !== el(4'h0)) $display("FAIL mrst_led got %h want %h", led, el(4'h0)); else passed++;
    checks++; if (step !== 1'b0) $display("FAIL mrst_step got %b want 0", step); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (led !== el(4'h1)) $display("FAIL mrst_switch_led got %h want %h", led, el(4'h1)); else passed++;
    wait_step(n, ok);
    checks++; if (!ok || n != 16) $display("FAIL mrst_first_tick got %0d want 16", n); else passed++;
    checks++; if (led !== el(4'h2)) $display("FAIL mrst_first_led got %h want %h", led, el(4'h2)); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; pause = 1'b0;
    test_reset();
    test_scan();
    test_rot();
    test_breath();
    test_pause();
    test_switch_on_tick();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
